// File: rtl/video_cfg_commit_ctrl.sv
// Frame-synchronous configuration scheduler: host stages address/data pairs in a FIFO,
// and the staged writes are replayed on an Avalon master only inside vertical blanking.
module video_cfg_commit_ctrl #(
   parameter int DEPTH = 8,
   parameter int AW    = 1,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    avs_address,
   input  logic          avs_write,
   input  logic [31:0]   avs_writedata,
   input  logic          avs_read,
   output logic [31:0]   avs_readdata,
   input  logic          frame_start,
   input  logic          frame_end,
   output logic [AW-1:0] avm_address,
   output logic          avm_write,
   output logic [DW-1:0] avm_writedata,
   output logic          commit_done
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = AW + DW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state;
   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [AW-1:0] addr_latch;

   logic push_req, push_ok, pop, ctrl_wr, flush, arm, full, empty;
   logic [31:0] status_word;

   // Avalon slave: a write/read strobe is accepted in the cycle it is high (no waitrequest);
   // read data appears exactly one cycle after avs_read. The master side has no backpressure.
   always_comb begin
      full        = (count == CW'(DEPTH));
      empty       = (count == '0);
      ctrl_wr     = avs_write && (avs_address == 2'd2);
      push_req    = avs_write && (avs_address == 2'd1);
      flush       = ctrl_wr && avs_writedata[1] && (state != DRAIN);
      arm         = ctrl_wr && avs_writedata[0] && !avs_writedata[1] && (state == IDLE);
      pop         = !flush && !empty && !frame_start &&
                    (((state == ARMED) && frame_end) || (state == DRAIN));
      push_ok     = push_req && (!full || pop);
      status_word = {19'd0, empty, full, overflow, (state == DRAIN), (state == ARMED), 8'(count)};
   end

   // Storage has no reset: only entries between rd_ptr and wr_ptr are ever read.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {addr_latch, avs_writedata[DW-1:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         addr_latch <= '0;
      end else begin
         if (avs_write && (avs_address == 2'd0)) addr_latch <= avs_writedata[AW-1:0];
         if (push_req && full && !pop) overflow <= 1'b1;
         else if (ctrl_wr && avs_writedata[2]) overflow <= 1'b0;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         avm_write     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         commit_done   <= 1'b0;
      end else begin
         commit_done <= 1'b0;
         avm_write   <= pop;
         if (pop) {avm_address, avm_writedata} <= mem[rd_ptr];
         case (state)
            IDLE: begin
               if (arm) state <= ARMED;
            end
            ARMED: begin
               if (flush) state <= IDLE;
               // A frame_end coinciding with frame_start leaves no blanking window.
               else if (frame_end && !frame_start) begin
                  if (empty) begin
                     commit_done <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (frame_start) state <= ARMED;
               else if (empty) begin
                  commit_done <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         avs_readdata <= '0;
      end else if (avs_read && (avs_address == 2'd3)) begin
         avs_readdata <= status_word;
      end else begin
         avs_readdata <= '0;
      end
   end

endmodule

// File: tb/tb_video_cfg_commit_ctrl.sv
// Directed bench for video_cfg_commit_ctrl: staging, frame-window replay, abort,
// overflow, flush and asynchronous reset behaviour.
module tb_video_cfg_commit_ctrl;

   localparam int DEPTH = 8;
   localparam int AW    = 1;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    avs_address = '0;
   logic          avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic          avs_read = 1'b0;
   logic [31:0]   avs_readdata;
   logic          frame_start = 1'b0;
   logic          frame_end = 1'b0;
   logic [AW-1:0] avm_address;
   logic          avm_write;
   logic [DW-1:0] avm_writedata;
   logic          commit_done;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   logic [AW+DW-1:0] obs_q[$];
   logic [AW+DW-1:0] exp_q[$];

   video_cfg_commit_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
      .avs_read(avs_read), .avs_readdata(avs_readdata),
      .frame_start(frame_start), .frame_end(frame_end),
      .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .commit_done(commit_done)
   );

   always #5 clk = ~clk;

   // Monitor: records every downstream write and commit pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (avm_write) obs_q.push_back({avm_address, avm_writedata});
         if (commit_done) done_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [1:0] a, input logic [31:0] d);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      step();
      avs_write = 1'b0;
   endtask

   task automatic host_read(input logic [1:0] a, output logic [31:0] d);
      avs_address = a; avs_read = 1'b1;
      step();
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic stage(input logic [AW-1:0] a, input logic [31:0] d);
      host_write(2'd0, 32'(a));
      host_write(2'd1, d);
   endtask

   task automatic pulse_frame_end();
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
   endtask

   task automatic clear_obs();
      obs_q.delete();
      exp_q.delete();
      done_cnt = 0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 40 && !commit_done; i++) step();
      n_checks++;
      if (commit_done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: commit_done got %b required 1", name, commit_done);
      end
      step();
   endtask

   task automatic compare_obs(input string name);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL %s_count: writes got %0d required %0d", name, obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL %s_write%0d: got %h required %h", name, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      n_checks++;
      if ({avm_write, commit_done, avm_address, avm_writedata, avs_readdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got w=%b d=%b a=%h wd=%h rd=%h required all 0",
                  avm_write, commit_done, avm_address, avm_writedata, avs_readdata);
      end
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h1000) begin n_fail++; $display("FAIL reset_status: got %h required 00001000", rd); end
      host_read(2'd0, rd);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL other_addr_read: got %h required 0", rd); end
   endtask

   task automatic test_commit_three();
      logic [31:0] rd;
      clear_obs();
      stage(1'b0, 32'h11); stage(1'b1, 32'h22); stage(1'b0, 32'h33);
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h3) begin n_fail++; $display("FAIL c3_staged_status: got %h required 00000003", rd); end
      host_write(2'd2, 32'h1);
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h103) begin n_fail++; $display("FAIL c3_armed_status: got %h required 00000103", rd); end
      pulse_frame_end();
      n_checks++;
      if ({avm_write, commit_done, avm_address, avm_writedata} !== {1'b1, 1'b0, 1'b0, 32'h11}) begin
         n_fail++; $display("FAIL c3_cycle1: got w=%b d=%b a=%h wd=%h required 1 0 0 11", avm_write, commit_done, avm_address, avm_writedata);
      end
      step();
      n_checks++;
      if ({avm_write, commit_done, avm_address, avm_writedata} !== {1'b1, 1'b0, 1'b1, 32'h22}) begin
         n_fail++; $display("FAIL c3_cycle2: got w=%b d=%b a=%h wd=%h required 1 0 1 22", avm_write, commit_done, avm_address, avm_writedata);
      end
      step();
      n_checks++;
      if ({avm_write, commit_done, avm_address, avm_writedata} !== {1'b1, 1'b0, 1'b0, 32'h33}) begin
         n_fail++; $display("FAIL c3_cycle3: got w=%b d=%b a=%h wd=%h required 1 0 0 33", avm_write, commit_done, avm_address, avm_writedata);
      end
      step();
      n_checks++;
      if ({avm_write, commit_done} !== 2'b01) begin
         n_fail++; $display("FAIL c3_done: got w=%b d=%b required w=0 d=1", avm_write, commit_done);
      end
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h1000) begin n_fail++; $display("FAIL c3_final_status: got %h required 00001000", rd); end
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      clear_obs();
      for (int i = 0; i <= DEPTH; i++) stage(AW'(i), 32'h100 + 32'(i));
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'hC08) begin n_fail++; $display("FAIL ovf_status: got %h required 00000c08", rd); end
      host_write(2'd2, 32'h4);
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h808) begin n_fail++; $display("FAIL ovf_clear: got %h required 00000808", rd); end
      host_write(2'd2, 32'h1);
      pulse_frame_end();
      wait_done("ovf_drain");
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), 32'h100 + 32'(i)});
      compare_obs("ovf_drain");
   endtask

   task automatic test_frame_start_abort();
      logic [31:0] rd;
      clear_obs();
      for (int i = 0; i < 5; i++) stage(AW'(i), 32'hA0 + 32'(i));
      host_write(2'd2, 32'h1);
      pulse_frame_end();
      step();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      n_checks++;
      if (avm_write !== 1'b0) begin n_fail++; $display("FAIL abort_write_stop: got %b required 0", avm_write); end
      step(); step();
      n_checks++;
      if (obs_q.size() != 2) begin n_fail++; $display("FAIL abort_writes: got %0d required 2", obs_q.size()); end
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h103) begin n_fail++; $display("FAIL abort_status: got %h required 00000103", rd); end
      pulse_frame_end();
      wait_done("abort_resume");
      for (int i = 0; i < 5; i++) exp_q.push_back({AW'(i), 32'hA0 + 32'(i)});
      compare_obs("abort_resume");
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL abort_done_cnt: got %0d required 1", done_cnt); end
   endtask

   task automatic test_empty_arm();
      logic [31:0] rd;
      clear_obs();
      host_write(2'd2, 32'h1);
      pulse_frame_end();
      n_checks++;
      if ({avm_write, commit_done} !== 2'b01) begin
         n_fail++; $display("FAIL empty_done: got w=%b d=%b required w=0 d=1", avm_write, commit_done);
      end
      step();
      n_checks++;
      if (commit_done !== 1'b0) begin n_fail++; $display("FAIL empty_done_pulse: got %b required 0", commit_done); end
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h1000 || obs_q.size() != 0) begin
         n_fail++; $display("FAIL empty_status: got %h writes %0d required 00001000 writes 0", rd, obs_q.size());
      end
   endtask

   task automatic test_flush();
      logic [31:0] rd;
      clear_obs();
      for (int i = 0; i < 4; i++) stage(AW'(i), 32'hF0 + 32'(i));
      host_write(2'd2, 32'h1);
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h104) begin n_fail++; $display("FAIL flush_armed: got %h required 00000104", rd); end
      host_write(2'd2, 32'h3);
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h1000) begin n_fail++; $display("FAIL flush_status: got %h required 00001000", rd); end
      pulse_frame_end();
      for (int i = 0; i < 6; i++) step();
      n_checks++;
      if (obs_q.size() != 0 || done_cnt != 0) begin
         n_fail++; $display("FAIL flush_no_writes: got writes %0d done %0d required 0 0", obs_q.size(), done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      clear_obs();
      stage(1'b0, 32'hB0); stage(1'b1, 32'hB1);
      host_write(2'd2, 32'h1);
      pulse_frame_end();
      host_write(2'd1, 32'hB2);
      wait_done("b2b");
      exp_q.push_back({1'b0, 32'hB0});
      exp_q.push_back({1'b1, 32'hB1});
      exp_q.push_back({1'b1, 32'hB2});
      compare_obs("b2b");
   endtask

   task automatic test_reset_mid_drain();
      logic [31:0] rd;
      clear_obs();
      for (int i = 0; i < 6; i++) stage(AW'(i), 32'hC0 + 32'(i));
      host_write(2'd2, 32'h1);
      pulse_frame_end();
      step();
      n_checks++;
      if (avm_write !== 1'b1) begin n_fail++; $display("FAIL rst_pre_write: got %b required 1", avm_write); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (avm_write !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop: got %b required 0", avm_write); end
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      host_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h1000) begin n_fail++; $display("FAIL rst_status: got %h required 00001000", rd); end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step();
      test_reset();
      test_commit_three();
      test_overflow();
      test_frame_start_abort();
      test_empty_arm();
      test_flush();
      test_back_to_back();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
